// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and defaults for the PLL reset sequencer: FSM state enum,
// default timing constants and the timer-width helper.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_rst_state_t;

    localparam int unsigned DEF_SYNC_STAGES    = 2;
    localparam int unsigned DEF_STABLE_CYCLES  = 2700;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 270000;
    localparam int unsigned DEF_PLL_RST_CYCLES = 27;
    localparam int unsigned DEF_CNT_W          = 8;

    // One shared timer must reach the largest of the three terminal counts.
    function automatic int unsigned timer_width(
        input int unsigned lock_timeout,
        input int unsigned stable_cycles,
        input int unsigned pll_rst_cycles
    );
        int unsigned m;
        int unsigned w;
        m = lock_timeout;
        if (stable_cycles > m) m = stable_cycles;
        if (pll_rst_cycles > m) m = pll_rst_cycles;
        w = $clog2(m + 1);
        if (w == 0) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Lock/request inputs and reset/status outputs of the PLL reset sequencer.
interface pll_reset_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             lock_in;
    logic             req_rst;
    logic             pll_reset;
    logic             sys_reset;
    logic             ready;
    logic             lock_fail;
    logic [CNT_W-1:0] relock_count;

    modport master (
        input  lock_in,
        input  req_rst,
        output pll_reset,
        output sys_reset,
        output ready,
        output lock_fail,
        output relock_count
    );

    modport slave (
        output lock_in,
        output req_rst,
        input  pll_reset,
        input  sys_reset,
        input  ready,
        input  lock_fail,
        input  relock_count
    );
endinterface

// File: rtl/pll_reset_sequencer_lock_sync.sv
// Asynchronous-reset flop chain bringing an asynchronous status bit into clk.
module lock_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences the PLL RESET pin and holds the system reset until the
// synchronized lock has been stable for STABLE_CYCLES cycles.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input logic                    clk,
    input logic                    reset,
    pll_reset_sequencer_if.master  bus
);

    localparam int unsigned TW = timer_width(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES);
    localparam logic [TW-1:0] PULSE_LAST   = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);

    logic             w_lock_s;
    pll_rst_state_t   r_state;
    pll_rst_state_t   w_next_state;
    logic [TW-1:0]    r_timer;
    logic             w_timer_clr;
    logic             w_relock_inc;
    logic             w_fail_set;

    logic             r_pll_reset;
    logic             r_sys_reset;
    logic             r_ready;
    logic             r_lock_fail;
    logic [CNT_W-1:0] r_relock_count;

    lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk     (clk),
        .rst     (reset),
        .i_async (bus.lock_in),
        .o_sync  (w_lock_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= PLL_RST;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Lock-driven transitions are resolved first so a lock drop in RUN still
    // counts when req_rst overrides the destination in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_relock_inc = 1'b0;
        w_fail_set   = 1'b0;
        case (r_state)
            PLL_RST: begin
                if (r_timer == PULSE_LAST) w_next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_next_state = STABLE;
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_next_state = PLL_RST;
                    w_fail_set   = 1'b1;
                end
            end
            STABLE: begin
                if (!w_lock_s) begin
                    w_next_state = WAIT_LOCK;
                end else if (r_timer == STABLE_LAST) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (!w_lock_s) begin
                    w_next_state = WAIT_LOCK;
                    w_relock_inc = 1'b1;
                end
            end
            default: w_next_state = PLL_RST;
        endcase
        if (bus.req_rst) begin
            w_next_state = PLL_RST;
            w_fail_set   = 1'b0;
        end
        w_timer_clr = bus.req_rst || (w_next_state != r_state);
    end

    // The timer is idle in RUN, so it never has to count past the largest
    // terminal value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_timer_clr) begin
            r_timer <= '0;
        end else if (r_state != RUN) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pll_reset    <= 1'b1;
            r_sys_reset    <= 1'b1;
            r_ready        <= 1'b0;
            r_lock_fail    <= 1'b0;
            r_relock_count <= '0;
        end else begin
            r_pll_reset <= (w_next_state == PLL_RST);
            r_sys_reset <= (w_next_state != RUN);
            r_ready     <= (w_next_state == RUN);
            if (w_fail_set) begin
                r_lock_fail <= 1'b1;
            end
            if (w_relock_inc && (r_relock_count != '1)) begin
                r_relock_count <= r_relock_count + 1'b1;
            end
        end
    end

    assign bus.pll_reset    = r_pll_reset;
    assign bus.sys_reset    = r_sys_reset;
    assign bus.ready        = r_ready;
    assign bus.lock_fail    = r_lock_fail;
    assign bus.relock_count = r_relock_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized bench for pll_reset_sequencer against a cycle-level model of
// pulse, lock-wait, qualification and run behaviour.
module tb_pll_reset_sequencer;

    localparam int SYNC       = 2;
    localparam int SC         = 8;
    localparam int LT         = 50;
    localparam int PRC        = 4;
    localparam int CW         = 2;
    localparam int RELOCK_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;

    pll_reset_sequencer_if #(.CNT_W(CW)) bus ();

    pll_reset_sequencer #(
        .SYNC_STAGES    (SYNC),
        .STABLE_CYCLES  (SC),
        .LOCK_TIMEOUT   (LT),
        .PLL_RST_CYCLES (PRC),
        .CNT_W          (CW)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: lock delay line plus counters for remaining pulse, time waited
    // for lock, good-lock run length and whether the system is released.
    bit m_sync [SYNC];
    int m_pulse_left;
    int m_waited;
    int m_good;
    bit m_qualifying;
    bit m_running;
    bit m_fail;
    int m_relock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
        m_pulse_left = PRC;
        m_waited     = 0;
        m_good       = 0;
        m_qualifying = 1'b0;
        m_running    = 1'b0;
        m_fail       = 1'b0;
        m_relock     = 0;
    endtask

    task automatic count_loss();
        if (m_relock < RELOCK_MAX) m_relock++;
    endtask

    task automatic model_step(input bit lin, input bit req);
        bit ls;
        ls = m_sync[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = lin;
        if (req) begin
            if (m_running && !ls) count_loss();
            m_running    = 1'b0;
            m_qualifying = 1'b0;
            m_pulse_left = PRC;
        end else if (m_pulse_left > 0) begin
            m_pulse_left--;
            if (m_pulse_left == 0) m_waited = 0;
        end else if (m_running) begin
            if (!ls) begin
                m_running = 1'b0;
                m_waited  = 0;
                count_loss();
            end
        end else if (m_qualifying) begin
            if (!ls) begin
                m_qualifying = 1'b0;
                m_waited     = 0;
            end else begin
                m_good++;
                if (m_good == SC) begin
                    m_qualifying = 1'b0;
                    m_running    = 1'b1;
                end
            end
        end else begin
            if (ls) begin
                m_qualifying = 1'b1;
                m_good       = 0;
            end else begin
                m_waited++;
                if (m_waited == LT) begin
                    m_pulse_left = PRC;
                    m_fail       = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("pll_reset", int'(bus.pll_reset), (m_pulse_left > 0) ? 1 : 0);
        check("sys_reset", int'(bus.sys_reset), m_running ? 0 : 1);
        check("ready", int'(bus.ready), m_running ? 1 : 0);
        check("lock_fail", int'(bus.lock_fail), int'(m_fail));
        check("relock_count", int'(bus.relock_count), m_relock);
    endtask

    task automatic cycle(input bit lin, input bit req);
        bus.lock_in = lin;
        bus.req_rst = req;
        @(posedge clk);
        model_step(lin, req);
        #1;
        check_outputs();
    endtask

    // Asserts reset between edges and checks the outputs before any edge.
    task automatic async_reset(input int delay);
        #(delay);
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        bus.req_rst = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int seg;
        int len;
        bit reached;
        rst         = 1'b1;
        bus.lock_in = 1'b0;
        bus.req_rst = 1'b0;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Lock arriving just before, on, and after the timeout boundary.
        for (int d = PRC + LT - 4; d <= PRC + LT + 3; d++) begin
            for (int i = 0; i < d; i++) cycle(1'b0, 1'b0);
            for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0);
            async_reset(2);
        end

        // Timeout, release, lock losses, then a re-request mid pulse.
        for (int i = 0; i < 60; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0);
            for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0);
        end
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0);

        // Glitch during qualification.
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0);

        // Async reset mid-qualification with sticky status set beforehand.
        for (int i = 0; i < 60; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 25; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            cycle(1'b1, 1'b0);
            if (m_qualifying && m_good == 5) reached = 1'b1;
        end
        async_reset(2);

        // Randomized segments.
        for (int s = 0; s < 160; s++) begin
            seg = $urandom_range(0, 9);
            if (seg <= 4) begin
                len = $urandom_range(5, 40);
                for (int i = 0; i < len; i++) cycle(1'b1, $urandom_range(0, 59) == 0);
            end else if (seg <= 6) begin
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) cycle(1'b0, $urandom_range(0, 59) == 0);
            end else if (seg <= 8) begin
                len = $urandom_range(20, 70);
                for (int i = 0; i < len; i++) cycle(1'b0, $urandom_range(0, 59) == 0);
            end else begin
                for (int i = 0; i < 10; i++) cycle($urandom_range(0, 1) == 1, 1'b0);
            end
            if ($urandom_range(0, 24) == 0) async_reset($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
